// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// to instruction memory and buffers returned words in a small circular queue
// that feeds decode over a valid/ready handshake. A redirect from execute
// flushes the queue and restarts fetch; an in-flight read is drained first.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_drain;
    logic          r_req;
    logic [31:0]   r_addr;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [31:0]   r_q_inst [QDEPTH];
    logic          r_valid;
    logic [31:0]   r_out;
    logic [31:0]   r_pc;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_count_pop;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_head_nxt;
    logic [31:0]   w_fetch_pc_inc;
    logic [31:0]   w_redirect_pc;
    logic [31:0]   w_nxt_pc;
    logic [31:0]   w_nxt_inst;

    // Queue bookkeeping and the head entry that will be visible next cycle.
    // When the queue drains to empty on a push, the pushed word bypasses
    // storage into the output registers so ack-to-valid stays one cycle.
    always_comb begin
        w_pop          = r_valid & inst_ready & ~redirect;
        w_push         = (r_state == S_REQ) & imem_ack & ~r_drain & ~redirect;
        w_count_pop    = r_count - CW'(w_pop);
        w_count_nxt    = w_count_pop + CW'(w_push);
        w_head_nxt     = w_pop ? r_head + PW'(1) : r_head;
        w_fetch_pc_inc = r_fetch_pc + 32'd4;
        w_redirect_pc  = {redirect_pc[31:2], 2'b00};
        w_nxt_pc       = r_q_pc[w_head_nxt];
        w_nxt_inst     = r_q_inst[w_head_nxt];
        if (w_count_pop == '0) begin
            w_nxt_pc   = r_fetch_pc;
            w_nxt_inst = imem_rdata;
        end
    end

    // Queue storage; contents are qualified by the count so need no reset.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_q_pc[r_tail]   <= r_fetch_pc;
            r_q_inst[r_tail] <= imem_rdata;
        end
    end

    // Fetch FSM, queue pointers and registered decode-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_drain    <= 1'b0;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_out      <= '0;
            r_pc       <= '0;
        end else begin
            if (redirect) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_valid <= 1'b0;
            end else begin
                r_head  <= w_head_nxt;
                r_count <= w_count_nxt;
                r_valid <= (w_count_nxt != '0);
                if (w_push) begin
                    r_tail <= r_tail + PW'(1);
                end
                if (w_count_nxt != '0) begin
                    r_pc  <= w_nxt_pc;
                    r_out <= w_nxt_inst;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (w_count_pop < QD) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        if (imem_ack) begin
                            // Read completes now: drop its data, nothing left to drain.
                            r_state <= S_IDLE;
                            r_req   <= 1'b0;
                            r_drain <= 1'b0;
                        end else begin
                            // Keep the stale read alive with its old address until acked.
                            r_drain <= 1'b1;
                        end
                    end else if (imem_ack) begin
                        if (r_drain) begin
                            r_drain <= 1'b0;
                            if (w_count_pop < QD) begin
                                r_addr <= r_fetch_pc;
                            end else begin
                                r_state <= S_IDLE;
                                r_req   <= 1'b0;
                            end
                        end else begin
                            r_fetch_pc <= w_fetch_pc_inc;
                            if (w_count_nxt < QD) begin
                                r_addr <= w_fetch_pc_inc;
                            end else begin
                                r_state <= S_IDLE;
                                r_req   <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = r_valid;
    assign inst_out   = r_out;
    assign inst_pc    = r_pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode: owns the PC, issues word reads to instruction memory, and buffers fetched instructions in a small queue.
- Hands instructions to decode over a valid/ready handshake.
- Accepts a single redirect (taken beq, jal, jr) from execute: flushes buffered and in-flight instructions and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- QDEPTH, 2, instruction queue entries (power of 2, ≥2).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  read request to instruction memory, held until acked.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  input  1  response strobe, one cycle; imem_rdata valid in that cycle.
- imem_rdata  input  32  instruction word.
- inst_valid  output  1  queue head valid to decode.
- inst_ready  input  1  decode accepts head this cycle.
- inst_out  output  32  head instruction.
- inst_pc  output  32  PC of head instruction.
- redirect  input  1  one-cycle redirect strobe from execute.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0.

Behaviour:
- Reset:
  - fetch_pc=RESET_PC; queue empty.
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0.
  - FSM=IDLE; the drain flag is cleared.
  - Reset overrides redirect and ack in the same cycle. An ack arriving after reset for a pre-reset request is ignored.
- FSM states and transitions:
  - IDLE -> REQ when the number of free queue slots is ≥1 and redirect=0. On that edge imem_addr=fetch_pc and imem_req=1.
  - REQ, ack with no redirect and drain=0:
    - Write {fetch_pc, imem_rdata} into the queue tail.
    - fetch_pc += 4.
    - Go to REQ again if a slot remains after this write and any same-cycle pop, else IDLE.
    - Back-to-back fetches: a new request issues the cycle after the ack, so throughput is one instruction per 2 cycles minimum.
  - REQ, ack with drain=1: discard data, clear drain, then proceed as IDLE.
  - IDLE or REQ, redirect=1:
    - Flush queue (count=0, inst_valid=0 next cycle).
    - fetch_pc=redirect_pc & ~3.
    - If a request is outstanding and not acked this cycle: set drain=1 and keep imem_req asserted with the old address until its ack, then issue a new request to the redirected PC.
    - If acked in the same cycle as the redirect: discard that data, drain stays 0.
    - If no request is outstanding: go to REQ at the new PC next cycle.
  - A second redirect while drain=1 only updates fetch_pc; it does not create a second drain.
- Queue:
  - Circular, QDEPTH entries.
  - Pop when inst_valid & inst_ready.
  - Simultaneous push and pop when full is legal: pop frees the slot and count is unchanged.
  - Pointers wrap modulo QDEPTH.
  - inst_out and inst_pc come from the head entry, registered, with no combinational path from imem_rdata.
- Latency:
  - The first instruction after reset or redirect appears on inst_valid 1 cycle after its ack, so minimum ack-to-valid is 1 cycle.
  - With a 1-cycle memory, reset to first inst_valid is 3 cycles.
- Redirect priority:
  - Redirect and pop in the same cycle: the pop is ignored because the queue flushes.
  - Redirect beats ack-write.
- Arithmetic:
  - fetch_pc increments modulo 2^32.
  - 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Invariants:
  - At most one outstanding request.
  - imem_addr changes only when imem_req=0 or on the ack edge.
  - No queue write when count=QDEPTH.

Test Plan:
- Reset, 1-cycle ack memory returning addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,4,8,C with matching inst_out; first inst_valid on cycle 3 after reset deassert.
- inst_ready=0 for 10 cycles -> exactly QDEPTH=2 entries buffered, imem_req drops to 0. Then ready=1 -> PCs 0,4 pop in order and fetch resumes at 8.
- Redirect to 32'h0000_0103 while the request to 8 is outstanding with 3-cycle ack latency -> the data for 8 is discarded. The next request is to 32'h100, and the first delivered inst_pc is 32'h100.
- Redirect in the same cycle as an ack and a pop with a full queue -> the queue is empty next cycle and the next delivered PC is redirect_pc.
- RESET_PC=32'hFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-request with the ack arriving 1 cycle later -> the ack is ignored and the first delivered PC is RESET_PC.
